// File: rtl/seq_divider.sv
// Sequential radix-2 restoring divider with start/busy/done handshake, one quotient bit per clock.
// Define SEQ_DIVIDER_SIGNED_EN for two's-complement operands; the default build divides unsigned operands.
module seq_divider #(
    parameter int WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [CW-1:0]    cnt_q,  cnt_d;
    logic [WIDTH-1:0] p_q,    p_d;
    logic [WIDTH-1:0] q_q,    q_d;
    logic [WIDTH-1:0] d_q,    d_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q,  rem_d;
    logic             dbz_q,  dbz_d;

    logic             accept;
    logic             divisor_zero;
    logic             cnt_tc;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH:0]   p_shift;
    logic [WIDTH:0]   p_diff;
    logic [WIDTH-1:0] res_quot;
    logic [WIDTH-1:0] res_rem;

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic qsign_q, qsign_d;
    logic rsign_q, rsign_d;

    // Magnitude of the most-negative value wraps to itself, which is the correct unsigned magnitude.
    assign dvd_mag  = i_dividend[WIDTH-1] ? (~i_dividend + 1'b1) : i_dividend;
    assign dvs_mag  = i_divisor[WIDTH-1]  ? (~i_divisor + 1'b1)  : i_divisor;
    assign res_quot = qsign_q ? (~q_q + 1'b1) : q_q;
    assign res_rem  = rsign_q ? (~p_q + 1'b1) : p_q;
`else
    assign dvd_mag  = i_dividend;
    assign dvs_mag  = i_divisor;
    assign res_quot = q_q;
    assign res_rem  = p_q;
`endif

    assign divisor_zero = (i_divisor == '0);
    assign accept       = i_start && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign cnt_tc       = (cnt_q == CW'(1));

    // The stored remainder is always below the divisor, so only the shifted value needs the extra bit.
    assign p_shift = {p_q, q_q[WIDTH-1]};
    assign p_diff  = p_shift - {1'b0, d_q};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d = divisor_zero ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (cnt_tc) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                if (i_start) begin
                    state_d = divisor_zero ? S_DONE : S_CALC;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        o_busy = 1'b0;
        o_done = 1'b0;
        case (state_q)
            S_CALC:  o_busy = 1'b1;
            S_FIX:   o_busy = 1'b1;
            S_DONE:  o_done = 1'b1;
            default: begin
                o_busy = 1'b0;
                o_done = 1'b0;
            end
        endcase
    end

    always_comb begin
        cnt_d  = cnt_q;
        p_d    = p_q;
        q_d    = q_q;
        d_d    = d_q;
        quot_d = quot_q;
        rem_d  = rem_q;
        dbz_d  = dbz_q;
`ifdef SEQ_DIVIDER_SIGNED_EN
        qsign_d = qsign_q;
        rsign_d = rsign_q;
`endif
        if (accept) begin
            if (divisor_zero) begin
                quot_d = '1;
                rem_d  = i_dividend;
                dbz_d  = 1'b1;
            end else begin
                cnt_d = CW'(WIDTH);
                p_d   = '0;
                q_d   = dvd_mag;
                d_d   = dvs_mag;
`ifdef SEQ_DIVIDER_SIGNED_EN
                qsign_d = i_dividend[WIDTH-1] ^ i_divisor[WIDTH-1];
                rsign_d = i_dividend[WIDTH-1];
`endif
            end
        end else if (state_q == S_CALC) begin
            cnt_d = cnt_q - 1'b1;
            if (p_diff[WIDTH]) begin
                p_d = p_shift[WIDTH-1:0];
                q_d = {q_q[WIDTH-2:0], 1'b0};
            end else begin
                p_d = p_diff[WIDTH-1:0];
                q_d = {q_q[WIDTH-2:0], 1'b1};
            end
        end else if (state_q == S_FIX) begin
            quot_d = res_quot;
            rem_d  = res_rem;
            dbz_d  = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q  <= '0;
            p_q    <= '0;
            q_q    <= '0;
            d_q    <= '0;
            quot_q <= '0;
            rem_q  <= '0;
            dbz_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            p_q    <= p_d;
            q_q    <= q_d;
            d_q    <= d_d;
            quot_q <= quot_d;
            rem_q  <= rem_d;
            dbz_q  <= dbz_d;
        end
    end

`ifdef SEQ_DIVIDER_SIGNED_EN
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            qsign_q <= 1'b0;
            rsign_q <= 1'b0;
        end else begin
            qsign_q <= qsign_d;
            rsign_q <= rsign_d;
        end
    end
`endif

    assign o_quotient    = quot_q;
    assign o_remainder   = rem_q;
    assign o_div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider (WIDTH=4); expectations follow SEQ_DIVIDER_SIGNED_EN.
module tb_seq_divider;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] dvd;
    logic [W-1:0] dvs;
    logic [W-1:0] quot;
    logic [W-1:0] rem;
    logic         busy;
    logic         done;
    logic         dbz;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    seq_divider #(.WIDTH(W)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_start       (start),
        .i_dividend    (dvd),
        .i_divisor     (dvs),
        .o_quotient    (quot),
        .o_remainder   (rem),
        .o_busy        (busy),
        .o_done        (done),
        .o_div_by_zero (dbz)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Waits for o_done, counting edges after the accepting edge; lat enters with edges already seen.
    task automatic wait_done(input int lat_in, output int lat_out);
        int lat;
        lat = lat_in;
        while (!done && lat < 30) begin
            @(posedge clk);
            #1;
            lat++;
        end
        lat_out = lat;
    endtask

    task automatic run_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] eq, input logic [W-1:0] er,
                           input logic edbz, input int elat);
        int lat;
        @(negedge clk);
        dvd   = a;
        dvs   = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check({tag, "_busy"}, busy, (elat > 0) ? 1 : 0);
        wait_done(0, lat);
        check({tag, "_lat"}, lat, elat);
        check({tag, "_quot"}, quot, eq);
        check({tag, "_rem"}, rem, er);
        check({tag, "_dbz"}, dbz, edbz);
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, done, 0);
    endtask

    initial begin
        int lat;
        int seen;
        rst   = 1'b1;
        start = 1'b0;
        dvd   = '0;
        dvs   = '0;
        #12;
        check("rst_quot", quot, 0);
        check("rst_rem", rem, 0);
        check("rst_dbz", dbz, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        @(negedge clk);
        rst = 1'b0;

        run_div("d7_3", 4'd7, 4'd3, 4'd2, 4'd1, 1'b0, 5);
        run_div("dz7", 4'd7, 4'd0, 4'hF, 4'd7, 1'b1, 0);
`ifdef SEQ_DIVIDER_SIGNED_EN
        run_div("s_m7_2", 4'b1001, 4'd2, 4'b1101, 4'b1111, 1'b0, 5);
        run_div("s_m8_m1", 4'b1000, 4'b1111, 4'b1000, 4'd0, 1'b0, 5);
        run_div("s_7_m2", 4'd7, 4'b1110, 4'b1101, 4'd1, 1'b0, 5);
        run_div("s_dz_m6", 4'b1010, 4'd0, 4'hF, 4'b1010, 1'b1, 0);
`else
        run_div("u9_7", 4'd9, 4'd7, 4'd1, 4'd2, 1'b0, 5);
        run_div("u15_1", 4'd15, 4'd1, 4'd15, 4'd0, 1'b0, 5);
        run_div("u14_5", 4'd14, 4'd5, 4'd2, 4'd4, 1'b0, 5);
        run_div("u3_7", 4'd3, 4'd7, 4'd0, 4'd3, 1'b0, 5);
        run_div("u8_15", 4'd8, 4'd15, 4'd0, 4'd8, 1'b0, 5);
`endif

        // start pulse while busy must be ignored
        @(negedge clk);
        dvd   = 4'd7;
        dvs   = 4'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b1;
        dvd   = 4'd15;
        dvs   = 4'd1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(2, lat);
        check("ign_lat", lat, 5);
        check("ign_quot", quot, 4'd2);
        check("ign_rem", rem, 4'd1);
        @(posedge clk);
        #1;

        // start held through busy and DONE: second division accepted right after first done
        @(negedge clk);
        dvd   = 4'd7;
        dvs   = 4'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        dvd = 4'd9;
        dvs = 4'd7;
        wait_done(0, lat);
        check("b2b_lat1", lat, 5);
        check("b2b_quot1", quot, 4'd2);
        check("b2b_rem1", rem, 4'd1);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b_busy2", busy, 1);
        wait_done(1, lat);
        check("b2b_gap", lat, 6);
`ifdef SEQ_DIVIDER_SIGNED_EN
        check("b2b_quot2", quot, 4'hF);
        check("b2b_rem2", rem, 4'd0);
`else
        check("b2b_quot2", quot, 4'd1);
        check("b2b_rem2", rem, 4'd2);
`endif
        @(posedge clk);
        #1;

        // reset two cycles into CALC
        @(negedge clk);
        dvd   = 4'd7;
        dvs   = 4'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_quot", quot, 0);
        check("abort_rem", rem, 0);
        check("abort_dbz", dbz, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (done) seen = 1;
        end
        check("abort_no_done", seen, 0);
        run_div("post_rst", 4'd7, 4'd3, 4'd2, 4'd1, 1'b0, 5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
# seq_divider

Sequential radix-2 restoring divider, the inverse companion to the team's `booth_algo` multiplier. It takes a dividend and divisor, iterates one quotient bit per clock, and returns quotient and remainder with a start/busy/done handshake. It sits beside the multiplier in the arithmetic datapath and uses the same operand width and clocking.

## Interface
- `WIDTH`, default 4: operand, quotient and remainder width in bits (valid range 2–32).
- `i_clk` in 1: clock; all state changes on its rising edge.
- `i_rst` in 1: reset, asynchronous, active-high.
- `i_start` in 1: request a division; sampled only when `o_busy`=0.
- `i_dividend` in WIDTH: dividend, captured on the accepting edge.
- `i_divisor` in WIDTH: divisor, captured on the accepting edge.
- `o_quotient` out WIDTH: registered quotient; holds the last result.
- `o_remainder` out WIDTH: registered remainder; holds the last result.
- `o_busy` out 1: high while a division is in progress (CALC and FIX states).
- `o_done` out 1: one-cycle pulse when the results are valid.
- `o_div_by_zero` out 1: registered flag; valid with `o_done` and held until the next `o_done`.

## Operation
- States:
  - IDLE: `o_busy`=0. `i_start`=1 captures operands. Goes to CALC, or to DONE if the divisor is zero.
  - CALC: performs WIDTH iterations; a counter loads WIDTH and decrements each cycle.
  - FIX: applies sign correction and writes the outputs.
  - DONE: `o_done`=1, `o_busy`=0. Goes to IDLE, or straight to CALC/DONE if `i_start`=1 in this cycle.
- On capture, the block stores the operand magnitudes and the result signs:
  - quotient sign = dividend sign XOR divisor sign;
  - remainder sign = dividend sign.
- Each CALC iteration works on a WIDTH+1-bit partial remainder P and a WIDTH-bit register Q:
  - shift {P,Q} left by 1;
  - P = P − |divisor|;
  - if P is negative, restore P and set the Q LSB to 0; otherwise set the Q LSB to 1.
- FIX:
  - `o_quotient` = Q, negated if the quotient sign is set;
  - `o_remainder` = P[WIDTH-1:0], negated if the remainder sign is set;
  - `o_div_by_zero` = 0.
- Rounding: truncation toward zero, so |remainder| < |divisor| and the remainder takes the sign of the dividend.
- Divide by zero: `o_quotient` = all ones, `o_remainder` = the raw dividend, `o_div_by_zero` = 1. These outputs are written on the IDLE→DONE edge.
- Overflow (signed build only): most-negative / −1 wraps. `o_quotient` = most-negative, `o_remainder` = 0, no flag is raised.
- `i_start` is ignored while `o_busy`=1. Operand changes after capture have no effect.
- Outputs change only on the FIX→DONE edge or the divide-by-zero capture edge.

## Timing
- Reset value of every output: 0. Reset also forces the state to IDLE and clears the counter and the internal registers.
- Reset mid-operation aborts the division immediately. No `o_done` is produced for the aborted operation.
- Let edge 0 be the edge that accepts `i_start`:
  - `o_busy`=1 after edge 0, through edge WIDTH+1;
  - CALC occupies edges 1..WIDTH;
  - FIX result is written at edge WIDTH+1;
  - `o_done`=1 for the one cycle between edges WIDTH+1 and WIDTH+2.
- Latency, start accept to `o_done`: WIDTH+1 edges. Divide by zero: 1 edge.
- Back-to-back: `i_start` high during the DONE cycle is accepted at the next edge. Throughput is one result per WIDTH+2 cycles.
- `o_done` is never asserted for two consecutive cycles unless two divide-by-zero requests arrive back-to-back.

## Configuration
- `SEQ_DIVIDER_SIGNED_EN` defined: operands and results are two's complement. Magnitude conversion and sign correction are active, as described above.
- `SEQ_DIVIDER_SIGNED_EN` undefined: operands are unsigned. Magnitude conversion and sign correction are removed, and FIX only writes Q and P directly. Latency is unchanged.

## Test plan
- Signed build, WIDTH=4, dividend 7, divisor 3 → `o_quotient`=4'd2, `o_remainder`=4'd1, `o_div_by_zero`=0. `o_done` pulses exactly 5 edges after acceptance.
- Signed build, dividend −7 (4'b1001), divisor 2 → `o_quotient`=4'b1101 (−3), `o_remainder`=4'b1111 (−1).
- Signed build, dividend −8, divisor −1 → `o_quotient`=4'b1000, `o_remainder`=0. Separately, dividend 7, divisor 0 → `o_quotient`=4'hF, `o_remainder`=4'd7, `o_div_by_zero`=1, with `o_done` 1 edge after acceptance.
- Unsigned build, dividend 9, divisor 7 → `o_quotient`=1, `o_remainder`=2. Also 15/1 → `o_quotient`=15, `o_remainder`=0.
- Check the handshake:
  - pulse `i_start` during `o_busy` with different operands → ignored, and the original result is returned;
  - hold `i_start` high through the DONE cycle → second division accepted, second `o_done` exactly 6 edges after the first.
- Assert `i_rst` two cycles into CALC → all outputs are 0 immediately, with no `o_done`. After release, a new 7/3 returns 2 rem 1.
